shift_unit_pipe: RTL

//   Parametrised, pipelined barrel shifter; successor to the single-cycle logical right shifter.

---
 rtl/shift_unit_pipe.sv | 129 ++++++++++++
 1 files changed

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with a global-stall valid/ready handshake.
// Slice 0 captures the raw operand. Each following register applies one group of
// STAGES_PER_REG log-shift stages to the slice before it. The output register applies
// the last group.
module shift_unit_pipe #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned STAGES_PER_REG = 2,
  parameter int unsigned TAG_W          = 5,
  localparam int unsigned SHAMT_W       = $clog2(WIDTH)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [2:0]         i_op,
  input  logic [WIDTH-1:0]   i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic [TAG_W-1:0]   i_tag,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WIDTH-1:0]   o_result,
  output logic [TAG_W-1:0]   o_tag,
  output logic               o_busy
);

  localparam int unsigned LAT = (SHAMT_W + STAGES_PER_REG - 1) / STAGES_PER_REG;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // Payload that travels with each op; sgn is the operand MSB captured at input for SRA fill
  typedef struct packed {
    logic [2:0]         op;
    logic               sgn;
    logic [SHAMT_W-1:0] shamt;
    logic [TAG_W-1:0]   tag;
    logic [WIDTH-1:0]   data;
  } slot_t;

  slot_t              slot_q  [LAT];
  logic [LAT-1:0]     vld_q;
  logic [WIDTH-1:0]   sh_data [LAT];
  logic               out_vld_q;
  logic [WIDTH-1:0]   res_q;
  logic [TAG_W-1:0]   tag_q;
  logic               advance_c;

  // One log-shift stage by s bit positions
  function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] d,
                                                   input logic [2:0] op,
                                                   input logic sgn,
                                                   input int unsigned s);
    logic [WIDTH-1:0] r;
    int unsigned lo;
    int unsigned hi;
    r = d;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      lo = (i + WIDTH - s) % WIDTH;
      hi = (i + s) % WIDTH;
      case (op)
        OP_SLL:  r[SHAMT_W'(i)] = (i >= s) ? d[SHAMT_W'(lo)] : 1'b0;
        OP_SRL:  r[SHAMT_W'(i)] = (i + s < WIDTH) ? d[SHAMT_W'(hi)] : 1'b0;
        OP_SRA:  r[SHAMT_W'(i)] = (i + s < WIDTH) ? d[SHAMT_W'(hi)] : sgn;
        OP_ROL:  r[SHAMT_W'(i)] = d[SHAMT_W'(lo)];
        OP_ROR:  r[SHAMT_W'(i)] = d[SHAMT_W'(hi)];
        default: r[SHAMT_W'(i)] = d[SHAMT_W'(i)];
      endcase
    end
    return r;
  endfunction

  // Apply the stages owned by register group grp (LSB-first)
  function automatic logic [WIDTH-1:0] group_shift(input slot_t s, input int unsigned grp);
    logic [WIDTH-1:0] d;
    d = s.data;
    for (int unsigned k = 0; k < SHAMT_W; k++) begin
      if (((k / STAGES_PER_REG) == grp) && (|(s.shamt & (SHAMT_W'(1) << k)))) begin
        d = shift_stage(d, s.op, s.sgn, 32'(1) << k);
      end
    end
    return d;
  endfunction

  // Global stall control and per-slice shift networks
  always_comb begin
    advance_c = ~out_vld_q | i_ready;
    for (int unsigned j = 0; j < LAT; j++) begin
      sh_data[j] = group_shift(slot_q[j], j);
    end
  end

  // Pipeline registers: reset beats flush, and flush beats advance
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vld_q     <= '0;
      out_vld_q <= 1'b0;
      res_q     <= '0;
      tag_q     <= '0;
      for (int unsigned j = 0; j < LAT; j++) begin
        slot_q[j] <= '0;
      end
    end else if (i_flush) begin
      vld_q     <= '0;
      out_vld_q <= 1'b0;
    end else if (advance_c) begin
      vld_q[0]  <= i_valid;
      slot_q[0] <= '{op: i_op, sgn: i_data[WIDTH-1], shamt: i_shamt, tag: i_tag, data: i_data};
      for (int unsigned j = 1; j < LAT; j++) begin
        vld_q[j]  <= vld_q[j-1];
        slot_q[j] <= '{op: slot_q[j-1].op, sgn: slot_q[j-1].sgn, shamt: slot_q[j-1].shamt,
                       tag: slot_q[j-1].tag, data: sh_data[j-1]};
      end
      out_vld_q <= vld_q[LAT-1];
      res_q     <= sh_data[LAT-1];
      tag_q     <= slot_q[LAT-1].tag;
    end
  end

  assign o_ready  = advance_c;
  assign o_valid  = out_vld_q;
  assign o_result = res_q;
  assign o_tag    = tag_q;
  assign o_busy   = (|vld_q) | out_vld_q;

endmodule
